// File: rtl/axil_wr_master.sv
// AXI4-Lite write-channel master: turns a single-cycle write request into AW/W/B
// handshakes and returns the response, with an optional response timeout.
module axil_wr_master #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    done,
    output logic [1:0]              resp,
    output logic                    timeout_err,
    output logic                    AWVALID,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWREADY,
    output logic                    WVALID,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WREADY,
    output logic                    BREADY,
    input  logic                    BVALID,
    input  logic [1:0]              BRESP
);

    localparam int               STRB_W      = DATA_WIDTH / 8;
    localparam int               CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(TIMEOUT);
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESP
    } state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_done;
    logic                    r_timeout_err;
    logic [1:0]              r_resp;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic [CNT_W-1:0]        r_cnt;

    state_t                  w_state_nxt;
    logic                    w_awvalid_nxt;
    logic                    w_wvalid_nxt;
    logic                    w_bready_nxt;
    logic                    w_done_nxt;
    logic                    w_timeout_err_nxt;
    logic [1:0]              w_resp_nxt;
    logic [ADDR_WIDTH-1:0]   w_awaddr_nxt;
    logic [DATA_WIDTH-1:0]   w_wdata_nxt;
    logic [STRB_W-1:0]       w_wstrb_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_timeout;
    logic                    w_b_hs;
    logic                    w_aw_done;
    logic                    w_w_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // The timeout fires on the edge where the incremented count reaches the limit.
    assign w_cnt_inc = sat_inc(r_cnt);
    assign w_timeout = (TIMEOUT > 0) && (w_cnt_inc == CNT_LIMIT);
    assign w_b_hs    = (r_state == S_WAIT_RESP) && r_bready && BVALID;
    assign w_aw_done = !r_awvalid || AWREADY;
    assign w_w_done  = !r_wvalid || WREADY;

    always_comb begin
        w_state_nxt       = r_state;
        w_awvalid_nxt     = r_awvalid;
        w_wvalid_nxt      = r_wvalid;
        w_bready_nxt      = r_bready;
        w_done_nxt        = 1'b0;
        w_timeout_err_nxt = 1'b0;
        w_resp_nxt        = r_resp;
        w_awaddr_nxt      = r_awaddr;
        w_wdata_nxt       = r_wdata;
        w_wstrb_nxt       = r_wstrb;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_awaddr_nxt  = req_addr;
                    w_wdata_nxt   = req_data;
                    w_wstrb_nxt   = req_strb;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_timeout) begin
                    w_awvalid_nxt     = 1'b0;
                    w_wvalid_nxt      = 1'b0;
                    w_bready_nxt      = 1'b0;
                    w_done_nxt        = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                    w_resp_nxt        = RESP_SLVERR;
                    w_state_nxt       = S_IDLE;
                end else begin
                    // AW and W retire independently; each valid drops after its own handshake.
                    if (AWREADY) begin
                        w_awvalid_nxt = 1'b0;
                    end
                    if (WREADY) begin
                        w_wvalid_nxt = 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        w_bready_nxt = 1'b1;
                        w_state_nxt  = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                w_cnt_nxt = w_cnt_inc;
                // A response arriving on the timeout edge takes priority over the timeout.
                if (w_b_hs) begin
                    w_resp_nxt   = BRESP;
                    w_done_nxt   = 1'b1;
                    w_bready_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if (w_timeout) begin
                    w_awvalid_nxt     = 1'b0;
                    w_wvalid_nxt      = 1'b0;
                    w_bready_nxt      = 1'b0;
                    w_done_nxt        = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                    w_resp_nxt        = RESP_SLVERR;
                    w_state_nxt       = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_resp        <= 2'b00;
            r_awaddr      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_ready   <= (w_state_nxt == S_IDLE);
            r_awvalid     <= w_awvalid_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_bready      <= w_bready_nxt;
            r_done        <= w_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_resp        <= w_resp_nxt;
            r_awaddr      <= w_awaddr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_wstrb       <= w_wstrb_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign req_ready   = r_req_ready;
    assign done        = r_done;
    assign resp        = r_resp;
    assign timeout_err = r_timeout_err;
    assign AWVALID     = r_awvalid;
    assign AWADDR      = r_awaddr;
    assign WVALID      = r_wvalid;
    assign WDATA       = r_wdata;
    assign WSTRB       = r_wstrb;
    assign BREADY      = r_bready;

endmodule

// File: doc/axil_wr_master.md
# axil_wr_master

AXI4-Lite write-channel master. Converts a simple single-cycle write request (address, data, byte strobes) into a compliant AW/W/B transaction sequence, and returns the write response to the requester. It sits directly upstream of the slave-side write FSM and drives its AW, W and B channels. A response timeout guarantees the requester is released if the slave never answers.

## Interface
- ADDR_WIDTH, 6, AWADDR/req_addr width
- DATA_WIDTH, 32, WDATA/req_data width; multiple of 8
- TIMEOUT, 64, max cycles from request accept to B handshake; 0 disables the timeout

Ports:
- CLK  in  1  clock, rising edge
- RSTn  in  1  reset, synchronous, active-low
- req_valid  in  1  write request present
- req_ready  out  1  master idle, request accepted on req_valid & req_ready
- req_addr  in  ADDR_WIDTH  write address
- req_data  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  byte strobes
- done  out  1  one-cycle pulse: transaction finished
- resp  out  2  response for the finished transaction, valid while done=1
- timeout_err  out  1  one-cycle pulse with done when the transaction timed out
- AWVALID / AWADDR  out  1 / ADDR_WIDTH  write address channel
- AWREADY  in  1  write address channel
- WVALID / WDATA / WSTRB  out  1 / DATA_WIDTH / DATA_WIDTH/8  write data channel
- WREADY  in  1  write data channel
- BREADY  out  1  write response channel
- BVALID / BRESP  in  1 / 2  write response channel

## Operation
- All outputs are registered.
- Reset values:
  - AWVALID, WVALID, BREADY, done, timeout_err = 0.
  - resp = 2'b00; AWADDR, WDATA, WSTRB = 0.
  - req_ready = 1 (state IDLE).
- States are IDLE, SEND and WAIT_RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture addr/data/strb into AWADDR/WDATA/WSTRB.
  - Set AWVALID = WVALID = 1, clear the timeout counter, go to SEND.
- SEND:
  - AWVALID and WVALID are independent.
  - Each drops on the edge after its own VALID & READY handshake; until then it stays high with its payload stable.
  - VALID never depends on READY. READY may be high before VALID.
  - When both handshakes have completed (same edge or different edges), go to WAIT_RESP with BREADY = 1.
- WAIT_RESP:
  - BREADY held high.
  - On BVALID & BREADY: capture BRESP into resp, pulse done, drop BREADY, go to IDLE.
- Any BRESP value is passed through unchanged.
- A strobe value of all zeros is still issued as a normal transaction.
- Timeout counter:
  - Width $clog2(TIMEOUT+1), saturating.
  - Increments every cycle in SEND and WAIT_RESP.
  - When it reaches TIMEOUT with no B handshake on that edge: drop AWVALID/WVALID/BREADY, pulse done and timeout_err with resp = 2'b10 (SLVERR), go to IDLE.
- Simultaneous B handshake and timeout on the same edge: the handshake wins; resp = BRESP and timeout_err = 0.
- Reset mid-transaction: all valids and BREADY are low on the edge after RSTn=0 is sampled. No done pulse. Return to IDLE.

## Timing
- The request is accepted on edge N. AWVALID and WVALID are high from cycle N+1.
- With AWREADY = WREADY = 1, both handshakes occur on edge N+1 and BREADY is high from cycle N+2.
- done is asserted in the cycle after the B handshake edge. req_ready is high in that same cycle, so a new request may be accepted then (back-to-back).
- A new request is never accepted in SEND or WAIT_RESP.
- Minimum request-to-done latency is 3 cycles, plus slave BVALID latency.

## Test plan
1. Ideal write:
   - Stimulus: req addr 0x04, data 0xDEADBEEF, strb 0xF; slave READYs high.
   - Required: AWVALID and WVALID high exactly 1 cycle each, with AWADDR=0x04, WDATA=0xDEADBEEF, WSTRB=0xF.
   - Required: BREADY until BVALID; done=1 with resp=2'b00.
2. Skewed handshakes:
   - Stimulus: AWREADY held low 3 cycles; WREADY high.
   - Required: WVALID drops after 1 cycle. AWVALID stays high for 4 cycles with AWADDR stable.
   - Required: BREADY only after AW completes; done follows the B handshake.
3. Timeout:
   - Stimulus: TIMEOUT=16; slave never asserts BVALID.
   - Required: done=1, timeout_err=1, resp=2'b10 exactly 16 cycles after accept. All valids and BREADY low. req_ready=1.
4. Back-to-back:
   - Stimulus: request (0x00, 0x11111111, 0xF), then (0x3C, 0x22220000, 0xC) held valid.
   - Required: the second request is accepted in the done cycle of the first. Second AW/W carries 0x3C/0x22220000/0xC. Two done pulses.
5. Reset mid-transaction:
   - Stimulus: RSTn=0 during WAIT_RESP.
   - Required: BREADY low on the next edge, no done pulse, req_ready=1 after reset.
6. Race and error pass-through:
   - Stimulus: BVALID with BRESP=2'b10 arrives on the timeout edge (TIMEOUT=16).
   - Required: done=1, resp=2'b10, timeout_err=0.
